// File: rtl/async_fifo_pkg.sv
// Shared helpers for both async FIFO controllers: pointer width rule, gray
// conversions and the legal synchronizer depth range.
package async_fifo_pkg;

  localparam int MAX_PTR_W       = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  function automatic int ptrWidth(input int addrW);
    return addrW + 1;
  endfunction

  // Callers zero-extend to MAX_PTR_W and truncate back, so any width up to 32 works.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
    logic [MAX_PTR_W-1:0] bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_gray_sync.sv
// Per-bit flop synchronizer and a vector wrapper that brings a gray pointer
// across a clock boundary and also presents its binary value.
module async_fifo_flop_sync #(
  parameter int FLOP_CNT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [FLOP_CNT-1:0] r_stages;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[FLOP_CNT-2:0], i_d};
    end
  end

  assign o_q = r_stages[FLOP_CNT-1];

endmodule

module async_fifo_gray_sync
  import async_fifo_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_grayAsync,
  output logic [WIDTH-1:0] o_syncGray,
  output logic [WIDTH-1:0] o_syncBin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    async_fifo_flop_sync #(
      .FLOP_CNT(SYNC_STAGES)
    ) u_flopSync (
      .clk    (clk),
      .reset_n(reset_n),
      .i_d    (i_grayAsync[i]),
      .o_q    (o_syncGray[i])
    );
  end

  assign o_syncBin = WIDTH'(gray2bin(MAX_PTR_W'(o_syncGray)));

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: synchronizes the write pointer,
// issues 1-cycle-latency RAM reads and feeds a 2-entry valid/ready buffer.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W:0]   wr_ptr_gray_async,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   rd_level
);

  localparam int PTR_W = ptrWidth(ADDR_W);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_badSyncStages
    $error("async_fifo_rd_ctrl: SYNC_STAGES must be 2 or 3");
  end

  logic [PTR_W-1:0]  w_wrSyncGray;
  logic [PTR_W-1:0]  w_wrSyncBin;
  logic [PTR_W-1:0]  w_rdBinNext;
  logic [PTR_W-1:0]  r_rdBin;
  logic [PTR_W-1:0]  r_rdPtrGray;
  logic              r_outV;
  logic              r_skidV;
  logic              r_inflight;
  logic [DATA_W-1:0] r_outData;
  logic [DATA_W-1:0] r_skidData;
  logic              w_pop;
  logic              w_issue;
  logic              w_toOut;
  logic [1:0]        w_occupancy;

  async_fifo_gray_sync #(
    .WIDTH      (PTR_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wrPtrSync (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_grayAsync(wr_ptr_gray_async),
    .o_syncGray (w_wrSyncGray),
    .o_syncBin  (w_wrSyncBin)
  );

  assign fifo_empty  = (r_rdPtrGray == w_wrSyncGray);
  assign rd_level    = w_wrSyncBin - r_rdBin;
  assign rd_ptr_gray = r_rdPtrGray;
  assign rd_valid    = r_outV;
  assign rd_data     = r_outData;

  // Words held or on their way, after this cycle's pop; never let it exceed two.
  assign w_pop       = r_outV && rd_ready;
  assign w_occupancy = {1'b0, r_outV} + {1'b0, r_skidV} + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = !fifo_empty && (w_occupancy < 2'd2);
  assign w_toOut     = (!r_outV || w_pop) && !r_skidV;
  assign w_rdBinNext = r_rdBin + PTR_W'(1);

  assign mem_ren   = w_issue;
  assign mem_raddr = r_rdBin[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdBin     <= '0;
      r_rdPtrGray <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rdBin     <= w_rdBinNext;
        r_rdPtrGray <= PTR_W'(bin2gray(MAX_PTR_W'(w_rdBinNext)));
      end
    end
  end

  // The skid word always has priority over the RAM word arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outV     <= 1'b0;
      r_outData  <= '0;
      r_skidV    <= 1'b0;
      r_skidData <= '0;
    end else begin
      if (w_pop) begin
        if (r_skidV) begin
          r_outData <= r_skidData;
          r_outV    <= 1'b1;
        end else if (r_inflight) begin
          r_outData <= mem_rdata;
          r_outV    <= 1'b1;
        end else begin
          r_outV <= 1'b0;
        end
      end else if (r_inflight && w_toOut) begin
        r_outData <= mem_rdata;
        r_outV    <= 1'b1;
      end

      if (r_inflight && !w_toOut) begin
        r_skidData <= mem_rdata;
        r_skidV    <= 1'b1;
      end else if (w_pop && r_skidV) begin
        r_skidV <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Scoreboard bench for async_fifo_rd_ctrl: the bench plays the write side and
// the RAM, and checks every consumer beat against the order of writes.
module tb_async_fifo_rd_ctrl;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W:0]   wr_ptr_gray_async = '0;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_empty;
  logic [ADDR_W:0]   rd_level;

  logic [7:0] ram [DEPTH];
  logic [7:0] ramRdata;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ [$];
  logic [4:0] wrBin;
  logic [4:0] issueCnt;
  int         renPulses;
  int         beats;
  int         cycle;
  int         firstRen;
  int         firstValid;
  int         firstBeat;
  int         lastBeat;
  logic       prevStall;
  logic [7:0] prevData;
  logic       haveLastRaddr;
  logic [3:0] lastRaddr;
  logic       sawWrap;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) ramRdata <= ram[mem_raddr];
  end
  assign mem_rdata = ramRdata;

  async_fifo_rd_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_ptr_gray_async(wr_ptr_gray_async),
    .rd_ptr_gray      (rd_ptr_gray),
    .mem_ren          (mem_ren),
    .mem_raddr        (mem_raddr),
    .mem_rdata        (mem_rdata),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .fifo_empty       (fifo_empty),
    .rd_level         (rd_level)
  );

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Runs at the falling edge: follows issued reads and retires consumer beats.
  task automatic monitorCycle();
    checkOutput("rdPtrGray", 32'(rd_ptr_gray), 32'(toGray(issueCnt)));
    if (mem_ren) begin
      checkOutput("memRaddr", 32'(mem_raddr), 32'(issueCnt[3:0]));
      if (haveLastRaddr && lastRaddr == 4'd15 && mem_raddr == 4'd0) sawWrap = 1'b1;
      haveLastRaddr = 1'b1;
      lastRaddr     = mem_raddr;
      if (firstRen < 0) firstRen = cycle;
      issueCnt  = issueCnt + 5'd1;
      renPulses++;
    end
    if (rd_valid && firstValid < 0) firstValid = cycle;
    if (rd_valid && !rd_ready) begin
      if (prevStall) checkOutput("holdData", 32'(rd_data), 32'(prevData));
      prevStall = 1'b1;
      prevData  = rd_data;
    end else begin
      prevStall = 1'b0;
    end
    if (rd_valid && rd_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousBeat", 32'd1, 32'd0);
      end else begin
        checkOutput("rdData", 32'(rd_data), 32'(expQ.pop_front()));
      end
      if (beats == 0) firstBeat = cycle;
      lastBeat = cycle;
      beats++;
    end
    cycle++;
  endtask

  task automatic applyStimulus(input logic ready, input logic doWrite, input logic [7:0] data, output logic wrote);
    @(posedge clk);
    #1;
    rd_ready = ready;
    wrote    = 1'b0;
    if (doWrite && (5'(wrBin - issueCnt) < 5'd16)) begin
      ram[wrBin[3:0]]   = data;
      wrBin             = wrBin + 5'd1;
      wr_ptr_gray_async = toGray(wrBin);
      expQ.push_back(data);
      wrote = 1'b1;
    end
    @(negedge clk);
    monitorCycle();
  endtask

  task automatic resetDut();
    reset_n           = 1'b0;
    rd_ready          = 1'b0;
    wr_ptr_gray_async = '0;
    wrBin             = '0;
    issueCnt          = '0;
    expQ.delete();
    renPulses     = 0;
    beats         = 0;
    cycle         = 0;
    firstRen      = -1;
    firstValid    = -1;
    firstBeat     = -1;
    lastBeat      = -1;
    prevStall     = 1'b0;
    prevData      = '0;
    haveLastRaddr = 1'b0;
    lastRaddr     = '0;
    sawWrap       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic wrote;
    int   written;

    // Reset values and an idle stretch
    resetDut();
    checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
    checkOutput("rstMemRen", 32'(mem_ren), 32'd0);
    checkOutput("rstRdPtrGray", 32'(rd_ptr_gray), 32'd0);
    checkOutput("rstRdLevel", 32'(rd_level), 32'd0);
    checkOutput("rstFifoEmpty", 32'(fifo_empty), 32'd1);
    checkOutput("rstRdData", 32'(rd_data), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00, wrote);
    checkOutput("idleRenPulses", 32'(renPulses), 32'd0);
    checkOutput("idleBeats", 32'(beats), 32'd0);

    // Single word: latency from write pointer change
    resetDut();
    applyStimulus(1'b0, 1'b1, 8'hA5, wrote);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 8'h00, wrote);
    checkOutput("singleRenCycle", 32'(firstRen), 32'd2);
    checkOutput("singleValidCycle", 32'(firstValid), 32'd4);
    checkOutput("singleRdValid", 32'(rd_valid), 32'd1);
    checkOutput("singleRdData", 32'(rd_data), 32'hA5);
    checkOutput("singleRdPtrGray", 32'(rd_ptr_gray), 32'h01);
    checkOutput("singleFifoEmpty", 32'(fifo_empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, wrote);
    applyStimulus(1'b0, 1'b0, 8'h00, wrote);
    checkOutput("singleBeats", 32'(beats), 32'd1);
    checkOutput("singleDrained", 32'(rd_valid), 32'd0);

    // Streaming: one word per cycle with the consumer always ready
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'(i), wrote);
    for (int n = 0; n < 30 && beats < 8; n++) applyStimulus(1'b1, 1'b0, 8'h00, wrote);
    applyStimulus(1'b1, 1'b0, 8'h00, wrote);
    checkOutput("streamBeats", 32'(beats), 32'd8);
    checkOutput("streamBackToBack", 32'(lastBeat - firstBeat), 32'd7);
    checkOutput("streamRdPtrGray", 32'(rd_ptr_gray), 32'h0C);
    checkOutput("streamRdLevel", 32'(rd_level), 32'd0);
    checkOutput("streamQueueEmpty", 32'(expQ.size()), 32'd0);

    // Backpressure: buffer fills to two words, the third stays in RAM
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(i), wrote);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, wrote);
    checkOutput("bpRenPulses", 32'(renPulses), 32'd2);
    checkOutput("bpRdValid", 32'(rd_valid), 32'd1);
    checkOutput("bpRdData", 32'(rd_data), 32'd0);
    checkOutput("bpRdLevel", 32'(rd_level), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00, wrote);
    checkOutput("bpBeats", 32'(beats), 32'd3);
    checkOutput("bpBackToBack", 32'(lastBeat - firstBeat), 32'd2);
    checkOutput("bpDrained", 32'(rd_valid), 32'd0);

    // Wrap: 40 words with a randomly stalling consumer
    resetDut();
    written = 0;
    for (int n = 0; n < 800 && !(written == 40 && beats == 40); n++) begin
      applyStimulus(1'($urandom_range(0, 1)), written < 40, 8'(written), wrote);
      if (wrote) written++;
    end
    checkOutput("wrapWritten", 32'(written), 32'd40);
    checkOutput("wrapBeats", 32'(beats), 32'd40);
    checkOutput("wrapRaddr15to0", 32'(sawWrap), 32'd1);
    checkOutput("wrapIssueCnt", 32'(issueCnt), 32'd8);
    checkOutput("wrapRdPtrGray", 32'(rd_ptr_gray), 32'h0C);
    checkOutput("wrapQueueEmpty", 32'(expQ.size()), 32'd0);

    // Reset while a word is presented and a read is being issued
    resetDut();
    for (int n = 0; n < 20 && !(rd_valid && mem_ren); n++) applyStimulus(1'b1, n < 8, 8'(n), wrote);
    checkOutput("midRstReached", 32'(rd_valid && mem_ren), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstRdValid", 32'(rd_valid), 32'd0);
    checkOutput("midRstMemRen", 32'(mem_ren), 32'd0);
    resetDut();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00, wrote);
    checkOutput("midRstBeats", 32'(beats), 32'd0);
    checkOutput("midRstRenPulses", 32'(renPulses), 32'd0);
    checkOutput("midRstRdValidAfter", 32'(rd_valid), 32'd0);
    checkOutput("midRstFifoEmpty", 32'(fifo_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
